// File: rtl/demux_vc.sv
`default_nettype none
// ============================================================================
// Module   : demux_vc
// Brief    : Routes a flit stream by its class bit into two VC FIFOs, each
//            drained by its own pop; raises pause near full, sticky error.
// Revision : 1.0
// ============================================================================
module demux_vc #(
  parameter int BITNUMBER   = 6,
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_BITS   = 2,
  parameter int ALMOST_FULL = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BITNUMBER-1:0] data_in,
  input  logic                 valid_in,
  input  logic                 pop_vc0,
  input  logic                 pop_vc1,
  output logic [BITNUMBER-1:0] data_out_vc0,
  output logic [BITNUMBER-1:0] data_out_vc1,
  output logic                 valid_out_vc0,
  output logic                 valid_out_vc1,
  output logic                 empty_vc0,
  output logic                 empty_vc1,
  output logic                 full_vc0,
  output logic                 full_vc1,
  output logic                 pause,
  output logic                 error
);

  localparam int                 c_NUM_VC   = 2;
  localparam logic [ADDR_BITS:0] c_DEPTH    = (ADDR_BITS+1)'(FIFO_DEPTH);
  localparam logic [ADDR_BITS:0] c_AF_LEVEL = (ADDR_BITS+1)'(ALMOST_FULL);

  logic [c_NUM_VC-1:0] pop_req;
  logic                tgt_vc;
  logic                error_q;
  logic                error_d;

  assign pop_req = {pop_vc1, pop_vc0};
  assign tgt_vc  = data_in[BITNUMBER-1];

  for (genvar v = 0; v < c_NUM_VC; v++) begin : g_vc
    logic [BITNUMBER-1:0] mem_q [FIFO_DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr_q;
    logic [ADDR_BITS-1:0] rd_ptr_q;
    logic [ADDR_BITS:0]   count_q;
    logic [ADDR_BITS:0]   count_d;
    logic [BITNUMBER-1:0] dout_q;
    logic [BITNUMBER-1:0] dout_d;
    logic                 vout_q;
    logic                 push;
    logic                 rd;
    logic                 wr;
    logic                 ovf;
    logic                 full;
    logic                 empty;

    assign push  = valid_in && (tgt_vc == 1'(v));
    assign empty = (count_q == '0);
    assign full  = (count_q == c_DEPTH);
    assign rd    = pop_req[v] && !empty;
    // A pop in the same cycle frees a slot, so a push into a full VC still lands.
    assign wr    = push && (!full || rd);
    assign ovf   = push && full && !rd;

    always_comb begin
      count_d = count_q;
      dout_d  = '0;
      unique case ({wr, rd})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (rd) begin
        dout_d = mem_q[rd_ptr_q];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        dout_q   <= '0;
        vout_q   <= 1'b0;
      end else begin
        if (wr) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (rd) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        count_q <= count_d;
        dout_q  <= dout_d;
        vout_q  <= rd;
      end
    end

    // Storage needs no reset: pointers and counts alone define what is valid.
    always_ff @(posedge clk) begin
      if (wr && !reset) begin
        mem_q[wr_ptr_q] <= data_in;
      end
    end
  end : g_vc

  assign error_d = error_q | g_vc[0].ovf | g_vc[1].ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign data_out_vc0  = g_vc[0].dout_q;
  assign data_out_vc1  = g_vc[1].dout_q;
  assign valid_out_vc0 = g_vc[0].vout_q;
  assign valid_out_vc1 = g_vc[1].vout_q;
  assign empty_vc0     = g_vc[0].empty;
  assign empty_vc1     = g_vc[1].empty;
  assign full_vc0      = g_vc[0].full;
  assign full_vc1      = g_vc[1].full;
  assign pause         = (g_vc[0].count_q >= c_AF_LEVEL) || (g_vc[1].count_q >= c_AF_LEVEL);
  assign error         = error_q;

endmodule : demux_vc
`default_nettype wire

// File: tb/tb_demux_vc.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_vc
// Brief    : Directed self-checking bench for demux_vc.
// Revision : 1.0
// ============================================================================
module tb_demux_vc;

  localparam int c_W = 6;

  logic           clk;
  logic           reset;
  logic [c_W-1:0] data_in;
  logic           valid_in;
  logic           pop_vc0;
  logic           pop_vc1;
  logic [c_W-1:0] data_out_vc0;
  logic [c_W-1:0] data_out_vc1;
  logic           valid_out_vc0;
  logic           valid_out_vc1;
  logic           empty_vc0;
  logic           empty_vc1;
  logic           full_vc0;
  logic           full_vc1;
  logic           pause;
  logic           error;

  int n_cmp = 0;
  int n_bad = 0;

  demux_vc #(
    .BITNUMBER  (6),
    .FIFO_DEPTH (4),
    .ADDR_BITS  (2),
    .ALMOST_FULL(3)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .pop_vc0      (pop_vc0),
    .pop_vc1      (pop_vc1),
    .data_out_vc0 (data_out_vc0),
    .data_out_vc1 (data_out_vc1),
    .valid_out_vc0(valid_out_vc0),
    .valid_out_vc1(valid_out_vc1),
    .empty_vc0    (empty_vc0),
    .empty_vc1    (empty_vc1),
    .full_vc0     (full_vc0),
    .full_vc1     (full_vc1),
    .pause        (pause),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_in = 1'b0;
    pop_vc0  = 1'b0;
    pop_vc1  = 1'b0;
    data_in  = '0;
  endtask

  task automatic push(input logic [c_W-1:0] d);
    idle();
    data_in  = d;
    valid_in = 1'b1;
    tick();
    idle();
  endtask

  task automatic pop0_expect(input string tag, input logic [c_W-1:0] d);
    idle();
    pop_vc0 = 1'b1;
    tick();
    idle();
    chk({tag, "_vld"}, 32'(valid_out_vc0), 32'd1);
    chk({tag, "_dat"}, 32'(data_out_vc0), 32'(d));
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset / idle state
    chk("rst_empty0", 32'(empty_vc0), 32'd1);
    chk("rst_empty1", 32'(empty_vc1), 32'd1);
    chk("rst_full",   32'({full_vc1, full_vc0}), 32'd0);
    chk("rst_pause",  32'(pause), 32'd0);
    chk("rst_error",  32'(error), 32'd0);
    chk("rst_valid",  32'({valid_out_vc1, valid_out_vc0}), 32'd0);

    // Class-bit routing and simultaneous pops
    push(6'h05);
    push(6'h25);
    chk("rt_empty", 32'({empty_vc1, empty_vc0}), 32'd0);
    pop_vc0 = 1'b1;
    pop_vc1 = 1'b1;
    tick();
    idle();
    chk("dual_v0", 32'(valid_out_vc0), 32'd1);
    chk("dual_d0", 32'(data_out_vc0), 32'h05);
    chk("dual_v1", 32'(valid_out_vc1), 32'd1);
    chk("dual_d1", 32'(data_out_vc1), 32'h25);
    tick();
    chk("dual_after_v", 32'({valid_out_vc1, valid_out_vc0}), 32'd0);
    chk("dual_after_d", 32'({data_out_vc1, data_out_vc0}), 32'd0);
    chk("dual_after_e", 32'({empty_vc1, empty_vc0}), 32'b11);

    // Fill VC0, pause threshold, overflow
    push(6'h01);
    push(6'h02);
    chk("af_pause2", 32'(pause), 32'd0);
    push(6'h03);
    chk("af_pause3", 32'(pause), 32'd1);
    chk("af_full3",  32'(full_vc0), 32'd0);
    push(6'h04);
    chk("full4", 32'(full_vc0), 32'd1);
    chk("err_pre", 32'(error), 32'd0);
    push(6'h07);
    chk("ovf_err",  32'(error), 32'd1);
    chk("ovf_full", 32'(full_vc0), 32'd1);
    pop0_expect("ord1", 6'h01);
    pop0_expect("ord2", 6'h02);
    pop0_expect("ord3", 6'h03);
    pop0_expect("ord4", 6'h04);
    chk("ord_empty", 32'(empty_vc0), 32'd1);
    pop_vc0 = 1'b1;
    tick();
    idle();
    chk("drop_07", 32'(valid_out_vc0), 32'd0);
    chk("err_sticky", 32'(error), 32'd1);

    do_reset();
    chk("err_cleared", 32'(error), 32'd0);

    // Push into empty VC with same-cycle pop: no bypass
    data_in  = 6'h11;
    valid_in = 1'b1;
    pop_vc0  = 1'b1;
    tick();
    idle();
    chk("nobyp_v", 32'(valid_out_vc0), 32'd0);
    chk("nobyp_e", 32'(empty_vc0), 32'd0);
    pop0_expect("nobyp_rd", 6'h11);

    // VC1 wrap: interleaved push/pop of 0x21..0x26
    push(6'h21);
    for (int i = 1; i < 6; i++) begin
      data_in  = 6'(6'h21 + i);
      valid_in = 1'b1;
      pop_vc1  = 1'b1;
      tick();
      idle();
      chk("wrap_v", 32'(valid_out_vc1), 32'd1);
      chk("wrap_d", 32'(data_out_vc1), 32'(6'h21 + i - 1));
    end
    pop_vc1 = 1'b1;
    tick();
    idle();
    chk("wrap_last", 32'(data_out_vc1), 32'h26);
    chk("wrap_empty", 32'(empty_vc1), 32'd1);

    // Push + pop on a full VC
    push(6'h01);
    push(6'h02);
    push(6'h03);
    push(6'h04);
    chk("fpp_full_pre", 32'(full_vc0), 32'd1);
    data_in  = 6'h0A;
    valid_in = 1'b1;
    pop_vc0  = 1'b1;
    tick();
    idle();
    chk("fpp_dat",  32'(data_out_vc0), 32'h01);
    chk("fpp_err",  32'(error), 32'd0);
    chk("fpp_full", 32'(full_vc0), 32'd1);
    pop0_expect("fpp2", 6'h02);
    pop0_expect("fpp3", 6'h03);
    pop0_expect("fpp4", 6'h04);
    pop0_expect("fppA", 6'h0A);
    chk("fpp_empty", 32'(empty_vc0), 32'd1);

    // Reset mid-stream discards stored flits; reset wins over a push
    push(6'h01);
    push(6'h02);
    data_in  = 6'h03;
    valid_in = 1'b1;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    chk("mid_empty", 32'({empty_vc1, empty_vc0}), 32'b11);
    chk("mid_pause", 32'(pause), 32'd0);
    chk("mid_error", 32'(error), 32'd0);
    pop_vc0 = 1'b1;
    tick();
    idle();
    chk("mid_pop", 32'(valid_out_vc0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_demux_vc
`default_nettype wire
